// File: rtl/display_scan_ctrl_if.sv
// Bus between the BCD producer and the digit scanner: value/load/blanking
// inputs plus the registered decoder and anode drive.
interface display_scan_ctrl_if #(
   parameter int unsigned N_DIGITS = 4
);
   localparam int unsigned IW = $clog2(N_DIGITS);

   logic                    Load;
   logic [4*N_DIGITS-1:0]   Value;
   logic                    LZB;
   logic [3:0]              BCD;
   logic [N_DIGITS-1:0]     An;
   logic [IW-1:0]           Digit;
   logic                    FrameTick;

   modport master (
      output Load, Value, LZB,
      input  BCD, An, Digit, FrameTick
   );

   modport slave (
      input  Load, Value, LZB,
      output BCD, An, Digit, FrameTick
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: BLANK/DRIVE sequencing per digit,
// double-buffered frame value and leading-zero / invalid-digit blanking.
module display_scan_ctrl #(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   display_scan_ctrl_if.slave   bus
);

   localparam int unsigned IW   = $clog2(N_DIGITS);
   localparam int unsigned CMAX = (GUARD > REFRESH_DIV) ? GUARD : REFRESH_DIV;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic {
      BLANK,
      DRIVE
   } state_t;

   state_t                    state, state_n;
   logic [CW-1:0]             cnt, cnt_n;
   logic [IW-1:0]             idx, idx_n;
   logic [N_DIGITS-1:0][3:0]  pending, pending_n;
   logic [N_DIGITS-1:0][3:0]  shadow, shadow_n;
   logic                      frame_end;
   logic [N_DIGITS-1:0]       lz;
   logic [3:0]                cur_digit;
   logic                      blank;
   logic [N_DIGITS-1:0]       an_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= BLANK;
         cnt           <= '0;
         idx           <= '0;
         pending       <= '0;
         shadow        <= '0;
         bus.An        <= '1;
         bus.BCD       <= '0;
         bus.Digit     <= '0;
         bus.FrameTick <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         idx           <= idx_n;
         pending       <= pending_n;
         shadow        <= shadow_n;
         bus.An        <= an_n;
         bus.BCD       <= cur_digit;
         bus.Digit     <= idx_n;
         bus.FrameTick <= frame_end;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CW'(1);
      idx_n     = idx;
      frame_end = 1'b0;
      unique case (state)
         BLANK: begin
            if (cnt == CW'(GUARD - 1)) begin
               state_n = DRIVE;
               cnt_n   = '0;
            end
         end
         DRIVE: begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
               state_n = BLANK;
               cnt_n   = '0;
               if (idx == IW'(N_DIGITS - 1)) begin
                  idx_n     = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_n = idx + IW'(1);
               end
            end
         end
         default: begin
            state_n = BLANK;
            cnt_n   = '0;
         end
      endcase
   end

   // A Load landing on the wrap edge bypasses pending so the newest value wins.
   always_comb begin
      pending_n = bus.Load ? bus.Value : pending;
      shadow_n  = shadow;
      if (frame_end) begin
         shadow_n = bus.Load ? bus.Value : pending;
      end
   end

   // lz[g]: every digit from g up to the MSD is zero.
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_lz
      assign lz[g] = ~|shadow_n[N_DIGITS-1:g];
   end

   always_comb begin
      cur_digit = shadow_n[idx_n];
      blank     = (cur_digit > 4'd9) || (bus.LZB && (idx_n != '0) && lz[idx_n]);
      an_n      = '1;
      if ((state_n == DRIVE) && !blank) begin
         an_n[idx_n] = 1'b0;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, GUARD=2, REFRESH_DIV=4.
module tb_display_scan_ctrl;

   localparam int N     = 4;
   localparam int G     = 2;
   localparam int R     = 4;
   localparam int SLOT  = G + R;
   localparam int FRAME = N * SLOT;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   display_scan_ctrl_if #(.N_DIGITS(N)) bus ();

   display_scan_ctrl #(
      .N_DIGITS    (N),
      .REFRESH_DIV (R),
      .GUARD       (G)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Walks one frame from its first BLANK cycle; an_slots = {an3,an2,an1,an0}
   // are the DRIVE-phase anode patterns, dig the digits being shown.
   task automatic run_frame(input string tag, input logic [15:0] dig,
                            input logic [15:0] an_slots, input logic tick0,
                            input logic lzb,
                            input int la_p, input logic [15:0] la_v,
                            input int lb_p, input logic [15:0] lb_v);
      int         d;
      int         ph;
      logic [3:0] exp_an;
      bus.LZB = lzb;
      for (int p = 0; p < FRAME; p++) begin
         d      = p / SLOT;
         ph     = p % SLOT;
         exp_an = (ph < G) ? 4'hF : an_slots[4*d +: 4];
         chk($sformatf("%s p%0d An", tag, p), 16'(bus.An), 16'(exp_an));
         chk($sformatf("%s p%0d BCD", tag, p), 16'(bus.BCD), 16'(dig[4*d +: 4]));
         chk($sformatf("%s p%0d Digit", tag, p), 16'(bus.Digit), 16'(d));
         chk($sformatf("%s p%0d FrameTick", tag, p), 16'(bus.FrameTick),
             (p == 0) ? 16'(tick0) : 16'h0);
         if (p == la_p) begin
            bus.Load  = 1'b1;
            bus.Value = la_v;
         end else if (p == lb_p) begin
            bus.Load  = 1'b1;
            bus.Value = lb_v;
         end
         @(negedge clk);
         bus.Load = 1'b0;
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.Load  = 1'b0;
      bus.Value = '0;
      bus.LZB   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset An", 16'(bus.An), 16'hF);
      chk("reset BCD", 16'(bus.BCD), 16'h0);
      chk("reset Digit", 16'(bus.Digit), 16'h0);
      chk("reset FrameTick", 16'(bus.FrameTick), 16'h0);
      rst = 1'b0;

      run_frame("f1_first", 16'h0000, 16'h7BDE, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
      run_frame("f2_load1234", 16'h0000, 16'h7BDE, 1'b1, 1'b0, 10, 16'h1234, -1, 16'h0);
      run_frame("f3_show1234", 16'h1234, 16'h7BDE, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
      run_frame("f4_lzb_load0050", 16'h1234, 16'h7BDE, 1'b1, 1'b1, 5, 16'h0050, -1, 16'h0);
      run_frame("f5_show0050", 16'h0050, 16'hFFDE, 1'b1, 1'b1, 7, 16'h0000, -1, 16'h0);
      run_frame("f6_show0000_lzb", 16'h0000, 16'hFFFE, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
      run_frame("f7_show0000_nolzb", 16'h0000, 16'h7BDE, 1'b1, 1'b0, 12, 16'h00A1, -1, 16'h0);
      run_frame("f8_show00A1", 16'h00A1, 16'h7BFE, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);
      run_frame("f9_00A1_lzb_2loads", 16'h00A1, 16'hFFFE, 1'b1, 1'b1, 3, 16'h1111, 15, 16'h2222);
      run_frame("f10_show2222", 16'h2222, 16'h7BDE, 1'b1, 1'b1, 23, 16'h3333, -1, 16'h0);
      run_frame("f11_show3333", 16'h3333, 16'h7BDE, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);

      repeat (14) @(negedge clk);
      chk("pre-reset d2 An", 16'(bus.An), 16'hB);
      chk("pre-reset d2 Digit", 16'(bus.Digit), 16'h2);
      chk("pre-reset d2 BCD", 16'(bus.BCD), 16'h3);
      #2 rst = 1'b1;
      #1;
      chk("async reset An", 16'(bus.An), 16'hF);
      chk("async reset Digit", 16'(bus.Digit), 16'h0);
      chk("async reset BCD", 16'(bus.BCD), 16'h0);
      chk("async reset FrameTick", 16'(bus.FrameTick), 16'h0);
      @(negedge clk);
      rst = 1'b0;

      run_frame("r1_after_reset", 16'h0000, 16'hFFFE, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0);
      run_frame("r2_pending_cleared", 16'h0000, 16'hFFFE, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
